muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide responder for the EXECUTE stage. EX issues MUL*/DIV*/REM*
//  with a start pulse and stalls the pipe while the unit runs. The unit returns a one-cycle
//  valid result that EX muxes onto its ALU result path. Radix-2, one bit per cycle.
// PARAMETERS
//  XLEN   32  operand/result width; the counter is clog2(XLEN)+1 bits
// PORTS
//  CLK        in   1     clock; every register updates on the rising edge
//  RSTn       in   1     reset; synchronous, active-low
//  EN         in   1     pipeline enable; 0 freezes all state (no counter/state/datapath update)
//  flush_i    in   1     abort the current op (branch/hazard flush); sampled only when EN=1
//  start_i    in   1     issue request from EX; accepted only in IDLE with EN=1
//  funct3_i   in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op1_i      in   XLEN  rs1 value (post-forwarding)
//  op2_i      in   XLEN  rs2 value (post-forwarding)
//  stall_o    out  1     hold IF/ID/EX registers
//  valid_o    out  1     result_o valid for exactly this cycle
//  result_o   out  XLEN  product or quotient/remainder; 0 whenever valid_o=0
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all datapath registers=0; valid_o=0, result_o=0, stall_o=0.
//  States:
//   IDLE -> CALC  start_i accepted, no special case.
//   IDLE -> DONE  start_i accepted and the op is a special case.
//   CALC -> FIX   after XLEN iterations.
//   FIX  -> DONE  after 1 cycle.
//   DONE -> IDLE  after 1 cycle.
//  Accept (IDLE, start_i, EN=1):
//   - latch funct3 and the operand magnitudes; signed ops take the absolute value of signed operands.
//   - MULHSU: only op1 is signed.
//   - latch the result sign: MUL* = sign1^sign2; DIV = sign1^sign2; REM = sign1.
//  CALC, MUL*: shift-add of |op1|*|op2| into a 2*XLEN accumulator, one multiplier bit per cycle.
//  CALC, DIV*/REM*: restoring division on magnitudes, one quotient bit per cycle.
//  FIX: two's-complement negate when the latched sign=1, then select the output.
//   - MUL: low XLEN bits.  MULH*: high XLEN bits.
//   - DIV*: quotient.  REM*: remainder.
//  Special cases, decided in IDLE, no CALC/FIX:
//   - divisor=0: DIV/DIVU -> all ones; REM/REMU -> op1.
//   - signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
//  Latency (start sampled at edge N):
//   - normal ops: valid_o=1 in the cycle after edge N+XLEN+1, i.e. XLEN+2 cycles.
//   - special cases: valid_o=1 in the cycle after edge N, i.e. 1 cycle.
//  DONE: valid_o=1 and result_o=latched result for exactly one cycle.
//  stall_o = (state==IDLE & start_i) | state==CALC | state==FIX. stall_o=0 in DONE so EX advances.
//  start_i outside IDLE is ignored; it causes no error and is not queued.
//  The next op can be accepted in the cycle after DONE.
//  EN=0 in any state: hold everything; valid_o holds its value; stall_o follows state.
//  flush_i=1 (EN=1) in any state:
//   - next state IDLE; valid_o=0 next cycle.
//   - has priority over start_i, so a flush in IDLE with start_i is not accepted.
//  RSTn=0 mid-op: IDLE next edge; partial result discarded; no valid_o.
// TESTING
//  T1: MUL 7*(-3) -> valid_o at start+34 cycles, result_o=0xFFFFFFEB; stall_o high exactly 34 cycles.
//  T2: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//      MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  T3: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  T4: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000;
//      REM of the same operands -> 0; all at 1-cycle latency.
//  T5: EN=0 for 5 cycles mid-CALC -> valid_o delayed by exactly 5 cycles, result unchanged;
//      back-to-back start in the cycle after DONE is accepted.
//  T6: flush_i at cycle 10 of CALC, or RSTn=0 at cycle 10 -> no valid_o, stall_o=0 the next cycle;
//      a following DIVU 9/3 returns 3.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Revision 1.0 - initial release.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            EN,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        funct3;
  logic              neg;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result;

  logic            is_div_in, signed1_in, signed2_in, sign1_in, sign2_in, neg_in;
  logic            div0_in, ovf_in, special_in;
  logic [XLEN-1:0] mag1_in, mag2_in, special_res;

  // Incoming op decode: operand magnitudes, result sign and the no-iteration cases.
  always_comb begin
    is_div_in   = funct3_i[2];
    signed1_in  = is_div_in ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    signed2_in  = is_div_in ? ~funct3_i[0] : ~funct3_i[1];
    sign1_in    = signed1_in & op1_i[XLEN-1];
    sign2_in    = signed2_in & op2_i[XLEN-1];
    mag1_in     = sign1_in ? -op1_i : op1_i;
    mag2_in     = sign2_in ? -op2_i : op2_i;
    neg_in      = (is_div_in & funct3_i[1]) ? sign1_in : (sign1_in ^ sign2_in);
    div0_in     = is_div_in & (op2_i == '0);
    ovf_in      = is_div_in & ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
    special_in  = div0_in | ovf_in;
    special_res = '0;
    if (div0_in)
      special_res = funct3_i[1] ? op1_i : '1;
    else if (ovf_in)
      special_res = funct3_i[1] ? '0 : op1_i;
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  // acc holds {high product, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = (div_shift >= {1'b0, opb});
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] mul_val;
  logic [XLEN-1:0]   mul_out, div_sel, div_out, fix_out;

  always_comb begin
    mul_val = neg ? -acc : acc;
    mul_out = (funct3[1:0] == 2'b00) ? mul_val[XLEN-1:0] : mul_val[2*XLEN-1:XLEN];
    div_sel = funct3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_out = neg ? -div_sel : div_sel;
    fix_out = funct3[2] ? div_out : mul_out;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state  <= IDLE;
      cnt    <= '0;
      funct3 <= '0;
      neg    <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (EN) begin
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              funct3 <= funct3_i;
              neg    <= neg_in;
              cnt    <= '0;
              if (special_in) begin
                result <= special_res;
                state  <= DONE;
              end else begin
                acc   <= {{XLEN{1'b0}}, (is_div_in ? mag1_in : mag2_in)};
                opb   <= is_div_in ? mag2_in : mag1_in;
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc <= funct3[2] ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER)
              state <= FIX;
          end
          FIX: begin
            result <= fix_out;
            state  <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign stall_o  = ((state == IDLE) & start_i) | (state == CALC) | (state == FIX);
  assign valid_o  = (state == DONE);
  assign result_o = valid_o ? result : '0;

endmodule
`default_nettype wire
